// File: rtl/apb_timer_pkg.sv
// rtl/apb_timer_pkg.sv - apb_timer shared constants and bus FSM state type (APB_TIMER_WAIT_STATE_EN adds ST_WAIT)
package apb_timer_pkg;

  // Register byte offsets within the peripheral window.
  localparam logic [4:0] ADDR_CTRL   = 5'h00;
  localparam logic [4:0] ADDR_PSC    = 5'h04;
  localparam logic [4:0] ADDR_ARR    = 5'h08;
  localparam logic [4:0] ADDR_CNT    = 5'h0C;
  localparam logic [4:0] ADDR_STATUS = 5'h10;

  // CTRL and STATUS bit positions.
  localparam int CTRL_EN    = 0;
  localparam int CTRL_CLR   = 1;
  localparam int CTRL_IE    = 2;
  localparam int STATUS_UIF = 0;

`ifdef APB_TIMER_WAIT_STATE_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2
  } bus_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1
  } bus_state_e;
`endif

endpackage

// File: rtl/apb_timer_core.sv
// rtl/apb_timer_core.sv - apb_timer prescaler, counter, tick and update-interrupt flag
module apb_timer_core
  import apb_timer_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic        i_clr,
  input  logic        i_uif_clr,
  input  logic [31:0] i_psc,
  input  logic [31:0] i_arr,
  output logic [31:0] o_cnt,
  output logic        o_uif
);

  logic [31:0] r_psc_cnt;
  logic [31:0] r_cnt;
  logic        r_uif;
  logic        w_tick;
  logic        w_wrap;

  // >= rather than == so a PSC lowered below the running count still ticks
  // on the next edge instead of running the full 32-bit range.
  assign w_tick = i_en && (r_psc_cnt >= i_psc);
  assign w_wrap = w_tick && (r_cnt >= i_arr);

  // Prescaler and main counter; a CLR write beats a simultaneous tick.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_psc_cnt <= '0;
      r_cnt     <= '0;
    end else if (i_clr) begin
      r_psc_cnt <= '0;
      r_cnt     <= '0;
    end else if (w_tick) begin
      r_psc_cnt <= '0;
      r_cnt     <= w_wrap ? 32'd0 : r_cnt + 32'd1;
    end else if (i_en) begin
      r_psc_cnt <= r_psc_cnt + 32'd1;
    end
  end

  // Update flag: a wrap sets it (unless CLR suppresses the wrap), set beats W1C.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_uif <= 1'b0;
    end else if (w_wrap && !i_clr) begin
      r_uif <= 1'b1;
    end else if (i_uif_clr) begin
      r_uif <= 1'b0;
    end
  end

  assign o_cnt = r_cnt;
  assign o_uif = r_uif;

endmodule

// File: rtl/apb_timer.sv
// rtl/apb_timer.sv - APB timer top: bus FSM, register file, core; APB_TIMER_WAIT_STATE_EN adds one wait state
module apb_timer
  import apb_timer_pkg::*;
(
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [4:0]  PADDR,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        irq
);

  bus_state_e  r_state;
  bus_state_e  w_state_nxt;
  logic        r_en;
  logic        r_ie;
  logic [31:0] r_psc;
  logic [31:0] r_arr;
  logic [31:0] w_cnt;
  logic        w_uif;
  logic [4:0]  w_addr;
  logic        w_wr;
  logic        w_clr;
  logic        w_uif_clr;
  logic [31:0] w_rdata;
  logic        w_unused_addr;

  // Byte-lane bits are not decoded; only word offsets select a register.
  assign w_addr        = {PADDR[4:2], 2'b00};
  assign w_unused_addr = ^PADDR[1:0];

`ifdef APB_TIMER_WAIT_STATE_EN
  assign PREADY = (r_state == ST_WAIT) && PSEL && PENABLE;
`else
  assign PREADY = (r_state == ST_ACCESS) && PSEL && PENABLE;
`endif

  assign w_wr      = PSEL && PENABLE && PWRITE && PREADY;
  assign w_clr     = w_wr && (w_addr == ADDR_CTRL) && PWDATA[CTRL_CLR];
  assign w_uif_clr = w_wr && (w_addr == ADDR_STATUS) && PWDATA[STATUS_UIF];

  // Bus FSM next state; losing PSEL in any active state abandons the transfer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (PSEL && !PENABLE) w_state_nxt = ST_ACCESS;
`ifdef APB_TIMER_WAIT_STATE_EN
      ST_ACCESS: if (!PSEL) w_state_nxt = ST_IDLE;
                 else if (PENABLE) w_state_nxt = ST_WAIT;
      ST_WAIT:   if (!PSEL || PREADY) w_state_nxt = ST_IDLE;
`else
      ST_ACCESS: if (!PSEL || PREADY) w_state_nxt = ST_IDLE;
`endif
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Bus FSM state register.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Writable registers; CLR is a pulse into the core and is never stored.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_en  <= 1'b0;
      r_ie  <= 1'b0;
      r_psc <= '0;
      r_arr <= '1;
    end else if (w_wr) begin
      case (w_addr)
        ADDR_CTRL: begin
          r_en <= PWDATA[CTRL_EN];
          r_ie <= PWDATA[CTRL_IE];
        end
        ADDR_PSC: r_psc <= PWDATA;
        ADDR_ARR: r_arr <= PWDATA;
        default:  ;
      endcase
    end
  end

  // Read mux; unmapped offsets read as zero.
  always_comb begin
    w_rdata = '0;
    case (w_addr)
      ADDR_CTRL: begin
        w_rdata[CTRL_EN] = r_en;
        w_rdata[CTRL_IE] = r_ie;
      end
      ADDR_PSC:    w_rdata = r_psc;
      ADDR_ARR:    w_rdata = r_arr;
      ADDR_CNT:    w_rdata = w_cnt;
      ADDR_STATUS: w_rdata[STATUS_UIF] = w_uif;
      default:     w_rdata = '0;
    endcase
  end

  assign PRDATA = PREADY ? w_rdata : 32'd0;
  assign irq    = w_uif && r_ie;

  apb_timer_core u_core (
    .i_clk     (PCLK),
    .i_rst     (PRESET),
    .i_en      (r_en),
    .i_clr     (w_clr),
    .i_uif_clr (w_uif_clr),
    .i_psc     (r_psc),
    .i_arr     (r_arr),
    .o_cnt     (w_cnt),
    .o_uif     (w_uif)
  );

endmodule
